// File: rtl/serial_deserializer_pkg.sv
// Shared types and sizing helpers for the bit-serial to parallel deserializer.
package deser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial input and parallel output handshakes of the deserializer.
interface serial_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/serial_deserializer_hold_reg.sv
// Output holding register: keeps the last completed word and a flag saying it is unconsumed.
module deser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  // A load wins over a take so a word completing on the take cycle keeps vld high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end else if (take) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Bit-serial to parallel converter: fills a shifter one bit at a time and
// hands each completed word to a holding register with valid/ready on both sides.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CW        = cnt_width(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  serial_deserializer_if.slave    bus,
  output logic [CW-1:0]           bit_cnt,
  output logic                    busy
);

  state_e           state;
  logic [WIDTH-1:0] sh_p0;
  logic [WIDTH-1:0] sh_nxt;
  logic             last;
  logic             take;
  logic             accept;
  logic             load;

  assign last          = (bit_cnt == CW'(WIDTH - 1));
  assign take          = bus.dout_valid && bus.dout_ready;
  // Only the completing bit can stall: it needs a free (or freeing) holding register.
  assign bus.din_ready = !(last && bus.dout_valid && !bus.dout_ready);
  assign accept        = bus.din_valid && bus.din_ready && !clr;
  assign load          = accept && last;

  always_comb begin
    sh_nxt = '0;
    if (MSB_FIRST) sh_nxt = {sh_p0[WIDTH-2:0], bus.din};
    else           sh_nxt = {bus.din, sh_p0[WIDTH-1:1]};
  end

  // Stage p0: shifter, bit counter and fill state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      bit_cnt <= '0;
      sh_p0   <= '0;
    end else if (clr) begin
      state   <= IDLE;
      busy    <= 1'b0;
      bit_cnt <= '0;
      sh_p0   <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          state <= FILL;
          busy  <= 1'b1;
        end
        FILL: begin
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (last) begin
        bit_cnt <= '0;
        sh_p0   <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        sh_p0   <= sh_nxt;
      end
    end
  end

  // Stage p1: completed word held for the consumer
  deser_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .take (take),
    .d    (sh_nxt),
    .q    (bus.dout),
    .vld  (bus.dout_valid)
  );

endmodule
